// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: ALU control decode, one-cycle simple ops, and an
// iterative shift-add multiplier retiring MUL_K multiplier bits per cycle.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int MUL_K  = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o
);

  localparam int STEPS = DATA_W / MUL_K;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_MUL  = 3'b110,
    OP_RELU = 3'b111
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state_reg, state_next;
  op_t               op;
  logic [DATA_W-1:0] simple_res;
  logic [DATA_W-1:0] mcand_reg, mplier_reg, acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] result_reg;
  logic              zero_reg;
  logic              accept, last_step;

  always_comb begin
    op = OP_ADD;
    if (ALUOp_i == 2'b01) begin
      op = OP_SUB;
    end else if (ALUOp_i == 2'b10) begin
      case (funct_i)
        10'b0100000000: op = OP_SUB;
        10'b0000001000: op = OP_MUL;
        10'b0000000110: op = OP_OR;
        10'b0000000111: op = OP_AND;
        10'b1000000111: op = OP_RELU;
        default:        op = OP_ADD;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SUB:  simple_res = src1_i - src2_i;
      OP_AND:  simple_res = src1_i & src2_i;
      OP_OR:   simple_res = src1_i | src2_i;
      OP_RELU: simple_res = src1_i[DATA_W-1] ? '0 : src1_i;
      default: simple_res = src1_i + src2_i;
    endcase
  end

  // One partial product per cycle; mcand/mplier shift so the low bits always line up.
  assign acc_next  = acc_reg + mcand_reg * DATA_W'(mplier_reg[MUL_K-1:0]);
  assign last_step = (cnt_reg == CNT_W'(STEPS - 1));

  assign ready_o = (state_reg == S_IDLE) || ((state_reg == S_DONE) && ready_i);
  assign accept  = valid_i && ready_o;
  assign valid_o = (state_reg == S_DONE);
  assign busy_o  = (state_reg == S_MUL);
  assign result_o = result_reg;
  assign zero_o   = zero_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (valid_i) state_next = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (last_step) state_next = S_DONE;
      S_DONE: begin
        if (ready_i) begin
          if (valid_i) state_next = (op == OP_MUL) ? S_MUL : S_DONE;
          else         state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand_reg  <= src1_i;
        mplier_reg <= src2_i;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else begin
        result_reg <= simple_res;
        zero_reg   <= (simple_res == '0);
      end
    end else if (state_reg == S_MUL) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << MUL_K;
      mplier_reg <= mplier_reg >> MUL_K;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (last_step) begin
        result_reg <= acc_next;
        zero_reg   <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one DUT with MUL_K=1, a second with MUL_K=4.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, valid2 = 1'b0;
  logic        ready = 1'b1, ready2 = 1'b1;
  logic [1:0]  aluop = 2'b00;
  logic [9:0]  funct = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        ready_o, valid_o, zero_o, busy_o;
  logic        ready_o2, valid_o2, zero_o2, busy_o2;
  logic [31:0] result_o, result_o2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(32), .MUL_K(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(ready_o),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(src1), .src2_i(src2),
    .valid_o(valid_o), .ready_i(ready), .result_o(result_o),
    .zero_o(zero_o), .busy_o(busy_o));

  alu_exec_unit #(.DATA_W(32), .MUL_K(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid2), .ready_o(ready_o2),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(src1), .src2_i(src2),
    .valid_o(valid_o2), .ready_i(ready2), .result_o(result_o2),
    .zero_o(zero_o2), .busy_o(busy_o2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] a, input logic [9:0] f,
                        input logic [31:0] s1, input logic [31:0] s2);
    aluop = a; funct = f; src1 = s1; src2 = s2;
  endtask

  // Single simple op from IDLE: accept on edge 0, check in cycle 1, return to IDLE.
  task automatic simple(input string tag, input logic [1:0] a, input logic [9:0] f,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] exp, input logic expz);
    set_op(a, f, s1, s2);
    valid = 1'b1; ready = 1'b1;
    step();
    valid = 1'b0;
    set_op(2'b00, '0, 32'hDEAD, 32'hBEEF);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_zero"}, 32'(zero_o), 32'(expz));
    $display("op %s: src1=%0h src2=%0h result=%0h zero=%0b", tag, s1, s2, result_o, zero_o);
    step();
    chk({tag, "_idle"}, 32'(valid_o), 32'd0);
    chk({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    // Reset with random inputs
    valid = 1'b1; valid2 = 1'b1;
    set_op(2'($urandom), 10'($urandom), $urandom, $urandom);
    ready = 1'($urandom); ready2 = 1'($urandom);
    repeat (3) step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_busy4", 32'(busy_o2), 32'd0);
    valid = 1'b0; valid2 = 1'b0; ready = 1'b1; ready2 = 1'b1;
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(ready_o), 32'd1);
    $display("reset: valid_o=%0b result=%0h ready_o=%0b", valid_o, result_o, ready_o);

    // Simple ops
    simple("add",     2'b10, 10'b0000000000, 32'd5, 32'd7, 32'd12, 1'b0);
    simple("sub",     2'b10, 10'b0100000000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
    simple("sub01",   2'b01, 10'b1111111111, 32'd9, 32'd9, 32'd0, 1'b1);
    simple("or",      2'b10, 10'b0000000110, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    simple("and",     2'b10, 10'b0000000111, 32'hF0, 32'h3C, 32'h30, 1'b0);
    simple("unk",     2'b10, 10'b0000000101, 32'd3, 32'd4, 32'd7, 1'b0);
    simple("add00",   2'b00, 10'b0100000000, 32'd20, 32'd22, 32'd42, 1'b0);
    simple("add11",   2'b11, 10'b0000001000, 32'd6, 32'd7, 32'd13, 1'b0);
    simple("relu_n",  2'b10, 10'b1000000111, 32'h80000001, 32'd5, 32'd0, 1'b1);
    simple("relu_p",  2'b10, 10'b1000000111, 32'd7, 32'hFFFF, 32'd7, 1'b0);

    // MUL, MUL_K=1: busy in cycles 1..32, valid at cycle 33
    set_op(2'b10, 10'b0000001000, 32'hFFFFFFFF, 32'd3);
    valid = 1'b1;
    step();
    valid = 1'b0;
    set_op(2'b00, '0, 32'h1, 32'h1);
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("mul1_busy_c%0d", c), {30'd0, busy_o, valid_o}, 32'b10);
      if (c == 1) chk("mul1_notready", 32'(ready_o), 32'd0);
      step();
    end
    chk("mul1_valid33", 32'(valid_o), 32'd1);
    chk("mul1_busy33", 32'(busy_o), 32'd0);
    chk("mul1_res", result_o, 32'hFFFFFFFD);
    chk("mul1_zero", 32'(zero_o), 32'd0);
    $display("mul k=1: FFFFFFFF*3 result=%0h at cycle 33", result_o);
    step();
    chk("mul1_idle", 32'(valid_o), 32'd0);

    // MUL 0x10000*0x10000 -> 0, bounded wait
    begin
      int lat;
      lat = 0;
      set_op(2'b10, 10'b0000001000, 32'h10000, 32'h10000);
      valid = 1'b1;
      step();
      valid = 1'b0;
      lat = 1;
      while (!valid_o && lat < 40) begin
        step();
        lat++;
      end
      chk("mulz_lat", 32'(lat), 32'd33);
      chk("mulz_res", result_o, 32'd0);
      chk("mulz_zero", 32'(zero_o), 32'd1);
      $display("mul k=1: 10000*10000 result=%0h zero=%0b latency=%0d", result_o, zero_o, lat);
      step();
    end

    // MUL, MUL_K=4 instance: busy 1..8, valid at cycle 9
    set_op(2'b10, 10'b0000001000, 32'hFFFFFFFF, 32'd3);
    valid2 = 1'b1;
    step();
    valid2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("mul4_busy_c%0d", c), {30'd0, busy_o2, valid_o2}, 32'b10);
      step();
    end
    chk("mul4_valid9", 32'(valid_o2), 32'd1);
    chk("mul4_res", result_o2, 32'hFFFFFFFD);
    $display("mul k=4: FFFFFFFF*3 result=%0h at cycle 9", result_o2);
    step();
    chk("mul4_idle", 32'(valid_o2), 32'd0);

    // Backpressure: hold DONE for 5 cycles, pulsed valid ignored
    set_op(2'b00, '0, 32'd10, 32'd20);
    valid = 1'b1; ready = 1'b0;
    step();
    valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        set_op(2'b11, '0, 32'd100, 32'd100);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      #1;
      chk($sformatf("bp_res_c%0d", c), result_o, 32'd30);
      chk($sformatf("bp_rdy_c%0d", c), {30'd0, ready_o, valid_o}, 32'b01);
      step();
    end
    chk("bp_ignored", result_o, 32'd30);
    $display("backpressure: result held=%0h valid_o=%0b", result_o, valid_o);
    set_op(2'b00, '0, 32'd40, 32'd2);
    ready = 1'b1; valid = 1'b1;
    #1;
    chk("bp_comb_ready", 32'(ready_o), 32'd1);
    step();
    valid = 1'b0;
    chk("bp_next_valid", 32'(valid_o), 32'd1);
    chk("bp_next_res", result_o, 32'd42);
    $display("backpressure release: new result=%0h", result_o);
    step();
    chk("bp_idle", 32'(valid_o), 32'd0);

    // Stream 4 ADDs at full throughput
    ready = 1'b1; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(2'b10, '0, 32'(i * 3), 32'd100);
      step();
      chk($sformatf("stream_v%0d", i), 32'(valid_o), 32'd1);
      chk($sformatf("stream_r%0d", i), result_o, 32'(i * 3 + 100));
      $display("stream %0d: result=%0h", i, result_o);
    end
    valid = 1'b0;
    step();
    chk("stream_end", 32'(valid_o), 32'd0);

    // Reset in the middle of a MUL
    set_op(2'b10, 10'b0000001000, 32'hFFFFFFFF, 32'd3);
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (9) step();
    chk("rstmul_busy_before", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmul_valid", 32'(valid_o), 32'd0);
    chk("rstmul_busy", 32'(busy_o), 32'd0);
    chk("rstmul_res", result_o, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    simple("post_rst", 2'b00, '0, 32'd1, 32'd1, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
